// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Accepts a pattern, a repeat count and an inter-frame gap through a
// valid/ready handshake. It sends the pattern MSB-first, one bit per clock,
// on x_out qualified by x_valid.
// Optional build macro SEQ_TX_ABORT_EN adds an abort input and an aborted
// pulse output that cancel a burst in flight.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
`ifdef SEQ_TX_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_nxt;
  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic [CNT_W-1:0] reps_q, reps_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic [GAP_W-1:0] gcnt_q, gcnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             abort_hit;

  // Next-state and next-counter logic. Outputs are registered from the next
  // state so that every output describes the state the block is in this cycle.
  always_comb begin
    state_nxt = state_q;
    pat_nxt   = pat_q;
    reps_nxt  = reps_q;
    gap_nxt   = gap_q;
    gcnt_nxt  = gcnt_q;
    idx_nxt   = idx_q;
    abort_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          pat_nxt   = pattern;
          reps_nxt  = repeat_cnt;
          gap_nxt   = gap;
          gcnt_nxt  = '0;
          idx_nxt   = IDX_MSB;
          state_nxt = (repeat_cnt == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_nxt = idx_q - IDX_W'(1);
        end else begin
          reps_nxt = reps_q - CNT_W'(1);
          if (reps_q == CNT_W'(1)) begin
            state_nxt = DONE;
          end else if (gap_q == '0) begin
            // Back-to-back frames: restart at the MSB with no bubble.
            idx_nxt = IDX_MSB;
          end else begin
            gcnt_nxt  = gap_q;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          gcnt_nxt  = '0;
          idx_nxt   = IDX_MSB;
          state_nxt = SEND;
        end else begin
          gcnt_nxt = gcnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef SEQ_TX_ABORT_EN
    // Abort only cancels live traffic; IDLE and DONE ignore it.
    if (abort && (state_q == SEND || state_q == GAP)) begin
      abort_hit = 1'b1;
      state_nxt = IDLE;
      reps_nxt  = '0;
      gcnt_nxt  = '0;
      idx_nxt   = IDX_MSB;
    end
`endif
  end

  // State, captured burst parameters and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= IDX_MSB;
    end else begin
      state_q <= state_nxt;
      pat_q   <= pat_nxt;
      reps_q  <= reps_nxt;
      gap_q   <= gap_nxt;
      gcnt_q  <= gcnt_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_ready <= 1'b1;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_ready <= (state_nxt == IDLE);
      x_valid     <= (state_nxt == SEND);
      x_out       <= (state_nxt == SEND) ? pat_nxt[idx_nxt] : 1'b0;
      frame_start <= (state_nxt == SEND) && (idx_nxt == IDX_MSB);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

  // Unused when the abort port is not present.
  logic abort_unused;
  assign abort_unused = abort_hit;

`ifdef SEQ_TX_ABORT_EN
  // One-cycle pulse acknowledging a cancelled burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx (PAT_W=4, CNT_W=8, GAP_W=4).
// Builds the expected per-cycle output stream in a queue when a burst is
// launched, then pops and compares one record per clock.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       x_out;
  logic       x_valid;
  logic       frame_start;
  logic       busy;
  logic       done;
`ifdef SEQ_TX_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern(pattern),
    .repeat_cnt(repeat_cnt),
    .gap(gap),
    .x_out(x_out),
    .x_valid(x_valid),
    .frame_start(frame_start),
    .busy(busy),
    .done(done)
`ifdef SEQ_TX_ABORT_EN
    ,
    .abort(abort),
    .aborted(aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic o;
    logic fs;
    logic dn;
    logic bs;
    logic rd;
  } exp_t;

  typedef struct {
    logic [3:0] pat;
    logic [7:0] r;
    logic [3:0] g;
    int         frames;
    int         len;
  } vec_t;

  exp_t q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   seen_frames;
  int   seen_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input logic v, input logic o, input logic fs,
                      input logic dn, input logic bs, input logic rd);
    exp_t e;
    e.v = v; e.o = o; e.fs = fs; e.dn = dn; e.bs = bs; e.rd = rd;
    q.push_back(e);
  endtask

  // Reference model: the expected stream for one burst, ending with DONE.
  task automatic push_burst(input logic [3:0] pat, input int r, input int g);
    for (int rep = 0; rep < r; rep++) begin
      for (int b = 3; b >= 0; b--) push(1'b1, pat[b], (b == 3), 1'b0, 1'b1, 1'b0);
      if (rep < r - 1)
        for (int k = 0; k < g; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // Compare one queued record per negedge; ends on the negedge of the last one.
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("x_valid", 32'(x_valid), 32'(e.v));
      chk("x_out", 32'(x_out), 32'(e.o));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("done", 32'(done), 32'(e.dn));
      chk("busy", 32'(busy), 32'(e.bs));
      chk("start_ready", 32'(start_ready), 32'(e.rd));
      if (frame_start === 1'b1) seen_frames++;
      if (busy === 1'b1 && done !== 1'b1) seen_len++;
      if (q.size() > 0) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    pattern = 4'b0000;
    repeat_cnt = 8'd0;
    gap = 4'd0;
`ifdef SEQ_TX_ABORT_EN
    abort = 1'b0;
`endif

    vecs[0] = '{pat: 4'b1010, r: 8'd1,   g: 4'd0,  frames: 1,   len: 4};
    vecs[1] = '{pat: 4'b1010, r: 8'd2,   g: 4'd2,  frames: 2,   len: 10};
    vecs[2] = '{pat: 4'b1100, r: 8'd3,   g: 4'd0,  frames: 3,   len: 12};
    vecs[3] = '{pat: 4'b1010, r: 8'd0,   g: 4'd3,  frames: 0,   len: 0};
    vecs[4] = '{pat: 4'b0110, r: 8'd1,   g: 4'd0,  frames: 1,   len: 4};
    vecs[5] = '{pat: 4'b1011, r: 8'd2,   g: 4'd15, frames: 2,   len: 23};
    vecs[6] = '{pat: 4'b0001, r: 8'd3,   g: 4'd1,  frames: 3,   len: 14};
    vecs[7] = '{pat: 4'b1001, r: 8'd255, g: 4'd0,  frames: 255, len: 1020};

    // Reset values, checked before any clock edge.
    #2;
    chk("rst start_ready", 32'(start_ready), 32'd1);
    chk("rst x_valid", 32'(x_valid), 32'd0);
    chk("rst x_out", 32'(x_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven bursts, one cycle of start_valid each.
    for (int i = 0; i < 8; i++) begin
      seen_frames = 0;
      seen_len = 0;
      push_burst(vecs[i].pat, int'(vecs[i].r), int'(vecs[i].g));
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("idle start_ready", 32'(start_ready), 32'd1);
      pattern = vecs[i].pat;
      repeat_cnt = vecs[i].r;
      gap = vecs[i].g;
      start_valid = 1'b1;
      @(negedge clk);
      cyc++;
      start_valid = 1'b0;
      pattern = ~vecs[i].pat;
      repeat_cnt = 8'd7;
      gap = 4'd9;
      drain();
      chk("frame count", 32'(seen_frames), 32'(vecs[i].frames));
      chk("traffic length", 32'(seen_len), 32'(vecs[i].len));
      @(negedge clk);
      cyc++;
    end

    // start_valid held across done: second burst starts on the first IDLE
    // cycle; a pattern change during the first burst only affects the second.
    push_burst(4'b0110, 1, 0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_burst(4'b1001, 1, 0);
    pattern = 4'b0110;
    repeat_cnt = 8'd1;
    gap = 4'd0;
    start_valid = 1'b1;
    @(negedge clk);
    cyc++;
    pattern = 4'b1001;
    drain();
    start_valid = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    cyc++;
    drain();
    @(negedge clk);
    cyc++;

    // Asynchronous reset two bits into a long burst.
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pattern = 4'b1010;
    repeat_cnt = 8'd5;
    gap = 4'd0;
    start_valid = 1'b1;
    @(negedge clk);
    cyc++;
    start_valid = 1'b0;
    drain();
    #1 rst = 1'b1;
    #1;
    chk("async rst x_valid", 32'(x_valid), 32'd0);
    chk("async rst x_out", 32'(x_out), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst start_ready", 32'(start_ready), 32'd1);
    chk("async rst frame_start", 32'(frame_start), 32'd0);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cyc++;
      chk("post rst x_valid", 32'(x_valid), 32'd0);
      chk("post rst start_ready", 32'(start_ready), 32'd1);
      chk("post rst busy", 32'(busy), 32'd0);
    end

`ifdef SEQ_TX_ABORT_EN
    // Abort during the first gap cycle.
    push_burst(4'b1010, 1, 0);
    void'(q.pop_back());
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pattern = 4'b1010;
    repeat_cnt = 8'd3;
    gap = 4'd3;
    start_valid = 1'b1;
    @(negedge clk);
    cyc++;
    start_valid = 1'b0;
    drain();
    abort = 1'b1;
    @(negedge clk);
    cyc++;
    abort = 1'b0;
    chk("abort aborted", 32'(aborted), 32'd1);
    chk("abort done", 32'(done), 32'd0);
    chk("abort x_valid", 32'(x_valid), 32'd0);
    chk("abort start_ready", 32'(start_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    cyc++;
    chk("abort pulse width", 32'(aborted), 32'd0);
    chk("abort no done", 32'(done), 32'd0);
    chk("abort no residue", 32'(x_valid), 32'd0);
    // Abort in IDLE is ignored.
    abort = 1'b1;
    @(negedge clk);
    cyc++;
    abort = 1'b0;
    chk("idle abort aborted", 32'(aborted), 32'd0);
    chk("idle abort start_ready", 32'(start_ready), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
